fetch_stage: RTL

3-wide in-order instruction fetch stage; sits directly upstream of icache.
- Holds the PC and drives three consecutive word addresses to icache.
- Consumes per-slot instruction/valid results from icache.
- Accepts the longest valid in-order prefix, limited by downstream free space.
- Registers accepted instructions into the IF/ID packet.
- Tells icache how far the fetch window advanced via shift, for its write-index tracking.

---
 rtl/fetch_stage.sv | 107 ++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: 3-wide in-order instruction fetch stage sitting directly upstream
// of the icache. Holds the PC and drives three consecutive word addresses. It
// accepts the longest valid in-order prefix of the icache results, limited by
// downstream free space, and registers it into the IF/ID packet.
//
// Ports:
//   clock, reset      - clock; synchronous active-high reset
//   cache_data        - per-slot instructions from icache (slot 2 = oldest)
//   cache_valid       - per-slot valid bits from icache
//   dispatch_free     - downstream slots free this cycle (0..3)
//   take_branch       - redirect request from the backend
//   target_pc         - redirect target (low two bits ignored)
//   proc2Icache_addr  - slot2 = PC, slot1 = PC+4, slot0 = PC+8
//   shift             - fetch window advance code to icache (0, 1 or 2)
//   if_inst           - registered fetched instructions
//   if_pc             - registered PCs of if_inst
//   if_valid          - registered slot valids
//   fetched_count     - total instructions accepted since reset (wraps)
module fetch_stage #(
    parameter int unsigned       XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = '0,
    parameter logic [31:0]       NOP_INST = 32'h00000013
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [2:0][31:0]          cache_data,
    input  logic [2:0]                cache_valid,
    input  logic [1:0]                dispatch_free,
    input  logic                      take_branch,
    input  logic [XLEN-1:0]           target_pc,
    output logic [2:0][XLEN-1:0]      proc2Icache_addr,
    output logic [1:0]                shift,
    output logic [2:0][31:0]          if_inst,
    output logic [2:0][XLEN-1:0]      if_pc,
    output logic [2:0]                if_valid,
    output logic [31:0]               fetched_count
);

    logic [XLEN-1:0] pc;
    logic [1:0]      prefix_len;
    logic [1:0]      acc;

    always_comb begin
        proc2Icache_addr[2] = pc;
        proc2Icache_addr[1] = pc + XLEN'(4);
        proc2Icache_addr[0] = pc + XLEN'(8);
    end

    // Longest in-order valid prefix starting at the oldest slot.
    always_comb begin
        prefix_len = 2'd0;
        if (cache_valid[2]) begin
            if (cache_valid[1]) begin
                prefix_len = cache_valid[0] ? 2'd3 : 2'd2;
            end else begin
                prefix_len = 2'd1;
            end
        end
    end

    // Reset is folded in so shift stays 0 while reset is held.
    always_comb begin
        acc = '0;
        if (!reset && !take_branch) begin
            acc = (prefix_len < dispatch_free) ? prefix_len : dispatch_free;
        end
    end

    // A full 3-wide advance is encoded as 0 toward the icache.
    always_comb begin
        shift = '0;
        if (acc == 2'd1) begin
            shift = 2'd1;
        end else if (acc == 2'd2) begin
            shift = 2'd2;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc            <= RESET_PC;
            fetched_count <= '0;
        end else if (take_branch) begin
            pc <= {target_pc[XLEN-1:2], 2'b00};
        end else begin
            pc            <= pc + (XLEN'(acc) << 2);
            fetched_count <= fetched_count + 32'(acc);
        end
    end

    // Packet refreshes every cycle; acc is already 0 under reset or redirect.
    // Slot i is accepted when it lies within the oldest acc slots (i >= 3-acc).
    always_ff @(posedge clock) begin
        for (int unsigned i = 0; i < 3; i++) begin
            if (32'(acc) + i >= 32'd3) begin
                if_valid[i] <= 1'b1;
                if_inst[i]  <= cache_data[i];
                if_pc[i]    <= proc2Icache_addr[i];
            end else begin
                if_valid[i] <= 1'b0;
                if_inst[i]  <= NOP_INST;
                if_pc[i]    <= '0;
            end
        end
    end

endmodule
